// File: rtl/issue_select.sv
// issue_select: select stage behind the issue-slot request/grant interface.
//
// Each cycle the oldest eligible slot (lowest index, slot 0 oldest) gets a
// one-hot grant. Its packet is latched into the issue register that feeds
// execute. When a uop leaves the issue register unkilled, its destination
// register travels down a WAKE_LAT-deep wakeup pipe. It is then broadcast on
// o_WDest so that issue slots can wake dependent sources.
//
// Handshake: the issue register is the valid side (o_valid) and execute is
// the ready side (i_ex_ready). A uop moves to execute on any edge where both
// are high. The register accepts a new uop whenever it is empty or draining
// that same cycle, so back-to-back issue runs at one uop per cycle.
//
// Ports:
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_request      : per-slot issue request
//   i_rslot        : slot packets, slot k at [k*WIDTH +: WIDTH]
//   i_BrKill       : branch kill mask, one-cycle pulse
//   i_ex_ready     : execute accepts the issue register this cycle
//   o_grant        : combinational one-hot grant back to the slots
//   o_valid, o_uop : issue register
//   o_WDest        : wakeup destination broadcast (0 = none)
//
// Packet layout, LSB first:
//   flags[2:0], pr1, pr2, prd, tag, brmask, opcode[6:0]
module issue_select #(
  parameter int N_SLOT    = 8,
  parameter int WIDTH_REG = 6,
  parameter int WIDTH_TAG = 4,
  parameter int WIDTH_BRM = 4,
  parameter int WAKE_LAT  = 2,
  parameter int WIDTH     = 7 + WIDTH_BRM + WIDTH_TAG + 3 * WIDTH_REG + 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_SLOT-1:0]         i_request,
  input  logic [N_SLOT*WIDTH-1:0]   i_rslot,
  input  logic [WIDTH_BRM-1:0]      i_BrKill,
  input  logic                      i_ex_ready,
  output logic [N_SLOT-1:0]         o_grant,
  output logic                      o_valid,
  output logic [WIDTH-1:0]          o_uop,
  output logic [WIDTH_REG-1:0]      o_WDest
);

  localparam int OFF_PRD = 3 + 2 * WIDTH_REG;
  localparam int OFF_BRM = 3 + 3 * WIDTH_REG + WIDTH_TAG;
  localparam int LAST    = WAKE_LAT - 1;

  // Issue register
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] uop_q, uop_d;

  // Wakeup pipe, stage 0 is youngest
  logic [WAKE_LAT-1:0]                wk_v_q, wk_v_d;
  logic [WAKE_LAT-1:0][WIDTH_REG-1:0] wk_prd_q, wk_prd_d;
  logic [WAKE_LAT-1:0][WIDTH_BRM-1:0] wk_brm_q, wk_brm_d;
  logic [WAKE_LAT-1:0]                wk_hit;
  logic [WIDTH_REG-1:0]               wdest_q, wdest_d;

  logic [N_SLOT-1:0]    eligible;
  logic [N_SLOT-1:0]    grant;
  logic [WIDTH-1:0]     sel_pkt;
  logic                 accept;
  logic [WIDTH_BRM-1:0] uop_brm;
  logic                 uop_kill;
  logic                 fire;

  // A slot whose branch mask hits this cycle's kill is already dead, so it
  // must not be granted even though it is still requesting.
  for (genvar k = 0; k < N_SLOT; k++) begin : g_elig
    assign eligible[k] = i_request[k] &&
      ((i_rslot[k*WIDTH + OFF_BRM +: WIDTH_BRM] & i_BrKill) == '0);
  end

  assign accept = !valid_q || i_ex_ready;

  // The lowest set bit of eligible is isolated as x & -x. Slot 0 is the
  // oldest, so this picks the oldest eligible slot. The grant is also held
  // at zero while reset is asserted.
  always_comb begin
    grant = eligible & (~eligible + N_SLOT'(1));
    if (!accept || !i_rst_n) grant = '0;
  end

  // The grant is one-hot, so a priority-free mux suffices.
  always_comb begin
    sel_pkt = '0;
    for (int k = 0; k < N_SLOT; k++) begin
      if (grant[k]) sel_pkt = i_rslot[k*WIDTH +: WIDTH];
    end
  end

  assign uop_brm  = uop_q[OFF_BRM +: WIDTH_BRM];
  assign uop_kill = (uop_brm & i_BrKill) != '0;
  // A killed uop does not count as executed, even if execute is ready.
  assign fire     = valid_q && i_ex_ready && !uop_kill;

  // When the register empties, o_uop keeps its old contents. Consumers
  // qualify it with o_valid.
  always_comb begin
    valid_d = valid_q;
    uop_d   = uop_q;
    if (grant != '0) begin
      valid_d = 1'b1;
      uop_d   = sel_pkt;
    end else if (valid_q && uop_kill) begin
      valid_d = 1'b0;
    end else if (valid_q && i_ex_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    for (int s = 0; s < WAKE_LAT; s++) begin
      wk_hit[s] = (wk_brm_q[s] & i_BrKill) != '0;
    end
  end

  // Each stage that is in flight is dropped when a kill hits its branch
  // mask. The output register applies the same filter, so a kill in any
  // cycle between fire and broadcast suppresses the wakeup.
  always_comb begin
    wk_v_d      = '0;
    wk_prd_d    = '0;
    wk_brm_d    = '0;
    wk_v_d[0]   = fire;
    wk_prd_d[0] = uop_q[OFF_PRD +: WIDTH_REG];
    wk_brm_d[0] = uop_brm;
    for (int s = 1; s < WAKE_LAT; s++) begin
      wk_v_d[s]   = wk_v_q[s-1] && !wk_hit[s-1];
      wk_prd_d[s] = wk_prd_q[s-1];
      wk_brm_d[s] = wk_brm_q[s-1];
    end
    wdest_d = (wk_v_q[LAST] && !wk_hit[LAST]) ? wk_prd_q[LAST] : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q  <= 1'b0;
      uop_q    <= '0;
      wk_v_q   <= '0;
      wk_prd_q <= '0;
      wk_brm_q <= '0;
      wdest_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      uop_q    <= uop_d;
      wk_v_q   <= wk_v_d;
      wk_prd_q <= wk_prd_d;
      wk_brm_q <= wk_brm_d;
      wdest_q  <= wdest_d;
    end
  end

  assign o_grant = grant;
  assign o_valid = valid_q;
  assign o_uop   = uop_q;
  assign o_WDest = wdest_q;

endmodule
